uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a byte on a `data_valid` pulse and latches the byte and the parity configuration. It then walks the frame (start, data LSB-first, optional parity, stop), one bit per `clk`. It drives the output-mux select, the serial data bit and the one-cycle enable required by the parity calculator, which samples `p_data` only on the cycle its enable is high.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk`  in  1  transmit bit clock; one frame bit per cycle. Reset is `rst`, asynchronous, active-low.
- `rst`  in  1  asynchronous active-low reset.
- `data_valid`  in  1  request to send `p_data_in`; sampled only in IDLE.
- `p_data_in`  in  DATA_WIDTH  payload.
- `par_en`  in  1  parity enable; latched on accept.
- `par_typ`  in  1  parity type (0 even, 1 odd); latched on accept.
- `data_reg`  out  DATA_WIDTH  latched payload; feeds the parity calculator's `p_data`.
- `par_typ_reg`  out  1  latched parity type; feeds the parity calculator.
- `par_calc_en`  out  1  one-cycle parity-capture enable.
- `ser_bit`  out  1  `data_reg[bit_idx]` during DATA, else 0.
- `mux_sel`  out  2  output select: 00 start (0), 01 idle/stop (1), 10 `ser_bit`, 11 parity bit.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse in the STOP cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Outputs are Moore-decoded from the registered state, except `ser_bit`, which is combinational from `data_reg` and `bit_idx`.
- **IDLE**
  - `mux_sel`=01, `busy`=0.
  - If `data_valid`=1 at an edge: latch `data_reg`<=`p_data_in`, `par_en_reg`<=`par_en`, `par_typ_reg`<=`par_typ`, `bit_idx`<=0, then go to START.
- **START**
  - `mux_sel`=00, `busy`=1.
  - `par_calc_en`=1 if `par_en_reg`=1, else 0. The parity bit is therefore valid from the end of START.
  - Next state: DATA.
- **DATA**
  - `mux_sel`=10, `busy`=1, `ser_bit`=`data_reg[bit_idx]`.
  - `bit_idx` increments each cycle.
  - When `bit_idx`=DATA_WIDTH-1: go to PARITY if `par_en_reg`=1, else STOP; `bit_idx`<=0.
- **PARITY**
  - `mux_sel`=11, `busy`=1.
  - Next state: STOP.
- **STOP**
  - `mux_sel`=01, `busy`=1, `frame_done`=1.
  - Next state: IDLE.
- `par_calc_en` is high only in START. It is never high for more than one consecutive cycle.
- `bit_idx` is $clog2(DATA_WIDTH) bits wide (minimum 1) and never exceeds DATA_WIDTH-1.
- `data_valid` outside IDLE is ignored. Nothing is queued and no error is flagged.
- Changes to `p_data_in`, `par_en` or `par_typ` while `busy`=1 have no effect on the current frame.

## Timing
- Reset values (asynchronous, immediate on `rst`=0):
  - state IDLE, `bit_idx` 0.
  - `data_reg` 0, `par_en_reg` 0, `par_typ_reg` 0.
  - `mux_sel` 01, `busy` 0, `par_calc_en` 0, `frame_done` 0, `ser_bit` 0.
- Latency: START is the cycle immediately after the accepting edge.
- Frame length, START through STOP:
  - DATA_WIDTH+3 cycles with parity.
  - DATA_WIDTH+2 cycles without parity.
- `busy` is high for exactly the frame length. `frame_done` is high in its last cycle.
- Back-to-back operation: if `data_valid` is held high, there is exactly one IDLE cycle between a STOP and the next START.
- Reset mid-frame: the line returns to idle (`mux_sel`=01) immediately and the frame is abandoned. The first accepted `data_valid` after `rst` deasserts starts a clean frame with `bit_idx`=0.

## Test plan
- **Reset, then 0xA5 with par_en=1, par_typ=0**
  - Frame is 11 cycles: `mux_sel` 00, then 10 ×8 with `ser_bit` 1,0,1,0,0,1,0,1, then 11, then 01.
  - `par_calc_en`=1 only in the START cycle; `busy`=1 for 11 cycles; `frame_done` in cycle 11.
- **0x3C with par_en=0**
  - Frame is 10 cycles with no 11 state; `ser_bit` 0,0,1,1,1,1,0,0.
  - `par_calc_en` stays 0 throughout; `par_typ_reg` equals the value sampled at accept.
- **`data_valid` held high with 0x01, then 0x80**
  - STOP, IDLE, START sequence on consecutive cycles.
  - The second frame's `ser_bit` is 0 ×7, then 1.
- **During DATA of 0x55 (bit_idx=2): pulse `data_valid` with 0xFF, set par_en=0, par_typ=1**
  - The current frame completes unchanged: parity state present, `par_typ_reg`=0.
  - No second frame starts.
- **`rst`=0 asserted at bit_idx=3 of frame 0x0F**
  - Outputs read `mux_sel`=01, `busy`=0, `data_reg`=0 before the next edge.
  - After release, `data_valid` with 0xF0 produces a full correct frame.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl_if
// Purpose  : Bundles the request and frame-control signals of the UART
//            transmit frame sequencer.
// Ports    : master - request side (drives data_valid, p_data_in, par_en,
//                     par_typ; observes the frame-control outputs)
//            slave  - sequencer side (the reverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  // request side
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data_in;
  logic                  par_en;
  logic                  par_typ;
  // frame-control side
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_typ_reg;
  logic                  par_calc_en;
  logic                  ser_bit;
  logic [1:0]            mux_sel;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output data_valid, p_data_in, par_en, par_typ,
    input  data_reg, par_typ_reg, par_calc_en, ser_bit, mux_sel, busy,
           frame_done
  );

  modport slave (
    input  data_valid, p_data_in, par_en, par_typ,
    output data_reg, par_typ_reg, par_calc_en, ser_bit, mux_sel, busy,
           frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit frame sequencer. Accepts a byte on data_valid
//            while idle, latches it together with the parity settings and
//            walks start, data (LSB first), optional parity and stop, one
//            bit per clk.
// Ports    : clk  - transmit bit clock
//            rst  - asynchronous active-low reset
//            bus  - uart_tx_ctrl_if.slave
//                   in : data_valid, p_data_in, par_en, par_typ
//                   out: data_reg, par_typ_reg, par_calc_en, ser_bit,
//                        mux_sel (00 start, 01 idle/stop, 10 data,
//                        11 parity), busy, frame_done
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] C_SEL_START  = 2'b00;
  localparam logic [1:0] C_SEL_IDLE   = 2'b01;
  localparam logic [1:0] C_SEL_DATA   = 2'b10;
  localparam logic [1:0] C_SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic [1:0]            w_mux_sel;
  logic                  w_busy;
  logic                  w_par_calc_en;
  logic                  w_frame_done;
  logic                  w_ser_bit;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Frame datapath: payload/parity latches and data bit index.
  // Latching only in IDLE is what makes input changes during a frame inert.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.data_valid) begin
            r_data    <= bus.p_data_in;
            r_par_en  <= bus.par_en;
            r_par_typ <= bus.par_typ;
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (r_bit_idx == C_LAST_IDX) begin
            r_bit_idx <= '0;
          end else begin
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        default: begin
          r_bit_idx <= r_bit_idx;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_mux_sel     = C_SEL_IDLE;
    w_busy        = 1'b0;
    w_par_calc_en = 1'b0;
    w_frame_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.data_valid) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_mux_sel     = C_SEL_START;
        w_busy        = 1'b1;
        // Parity calculator captures data_reg here so the parity bit is
        // settled well before the PARITY slot.
        w_par_calc_en = r_par_en;
        w_state_next  = S_DATA;
      end
      S_DATA: begin
        w_mux_sel = C_SEL_DATA;
        w_busy    = 1'b1;
        if (r_bit_idx == C_LAST_IDX) begin
          w_state_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_mux_sel    = C_SEL_PARITY;
        w_busy       = 1'b1;
        w_state_next = S_STOP;
      end
      S_STOP: begin
        w_mux_sel    = C_SEL_IDLE;
        w_busy       = 1'b1;
        w_frame_done = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Serial data bit is combinational so it tracks bit_idx in the same cycle.
  assign w_ser_bit = (r_state == S_DATA) ? r_data[r_bit_idx] : 1'b0;

  assign bus.data_reg    = r_data;
  assign bus.par_typ_reg = r_par_typ;
  assign bus.par_calc_en = w_par_calc_en;
  assign bus.ser_bit     = w_ser_bit;
  assign bus.mux_sel     = w_mux_sel;
  assign bus.busy        = w_busy;
  assign bus.frame_done  = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl. Stimulus pushes the
//            expected per-cycle frame outputs into a queue; a monitor pops
//            and compares one entry for every busy cycle and checks idle
//            outputs otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic clk;
  logic rst;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    mux;
    logic          ser;
    logic          pce;
    logic          fd;
    logic          ptyp;
    logic [DW-1:0] dreg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Expected cycle-by-cycle contents of one frame, START through STOP.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe,
                            input logic pt);
    exp_t e;
    e = '{mux: 2'b00, ser: 1'b0, pce: pe, fd: 1'b0, ptyp: pt, dreg: d};
    exp_q.push_back(e);
    for (int i = 0; i < DW; i++) begin
      e = '{mux: 2'b10, ser: d[i], pce: 1'b0, fd: 1'b0, ptyp: pt, dreg: d};
      exp_q.push_back(e);
    end
    if (pe) begin
      e = '{mux: 2'b11, ser: 1'b0, pce: 1'b0, fd: 1'b0, ptyp: pt, dreg: d};
      exp_q.push_back(e);
    end
    e = '{mux: 2'b01, ser: 1'b0, pce: 1'b0, fd: 1'b1, ptyp: pt, dreg: d};
    exp_q.push_back(e);
  endtask

  // Monitor: every busy cycle must match the next expected entry; idle
  // cycles must show the idle line with no strobes.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (rst) begin
      got = '{mux: bus.mux_sel, ser: bus.ser_bit, pce: bus.par_calc_en,
              fd: bus.frame_done, ptyp: bus.par_typ_reg, dreg: bus.data_reg};
      if (bus.busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy: got busy=1 mux=%b expected busy=0",
                   bus.mux_sel);
        end else begin
          want = exp_q.pop_front();
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL frame_cycle: got mux=%b ser=%b pce=%b fd=%b ptyp=%b dreg=%h expected mux=%b ser=%b pce=%b fd=%b ptyp=%b dreg=%h",
                     got.mux, got.ser, got.pce, got.fd, got.ptyp, got.dreg,
                     want.mux, want.ser, want.pce, want.fd, want.ptyp, want.dreg);
          end
        end
      end else begin
        chk("idle_outputs", {28'd0, bus.mux_sel, bus.par_calc_en, bus.frame_done},
            {28'd0, 2'b01, 1'b0, 1'b0});
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending entries expected 0", name,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(posedge clk);
    #1;
    bus.p_data_in  = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    push_frame(d, pe, pt);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.p_data_in  = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;

    // Reset state
    #3;
    chk("rst_mux_sel", {30'd0, bus.mux_sel}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_par_calc_en", {31'd0, bus.par_calc_en}, 32'd0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    chk("rst_ser_bit", {31'd0, bus.ser_bit}, 32'd0);
    chk("rst_data_reg", {24'd0, bus.data_reg}, 32'd0);
    chk("rst_par_typ_reg", {31'd0, bus.par_typ_reg}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 0xA5 with even parity: 11-cycle frame
    send(8'hA5, 1'b1, 1'b0);
    wait_idle("frame_a5");

    // 0x3C without parity, odd type latched then input changed mid-frame
    send(8'h3C, 1'b0, 1'b1);
    bus.par_typ = 1'b0;
    wait_idle("frame_3c");
    chk("3c_par_typ_reg", {31'd0, bus.par_typ_reg}, 32'd1);

    // Back-to-back: data_valid held high, 0x01 then 0x80
    @(posedge clk);
    #1;
    bus.p_data_in  = 8'h01;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.p_data_in = 8'h80;
    push_frame(8'h80, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done) seen = 1'b1;
    end
    chk("b2b_stop_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("b2b_idle_gap", {29'd0, bus.busy, bus.mux_sel}, {29'd0, 1'b0, 2'b01});
    @(negedge clk);
    chk("b2b_next_start", {29'd0, bus.busy, bus.mux_sel}, {29'd0, 1'b1, 2'b00});
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    wait_idle("frame_80");

    // 0x55 with parity; new request and settings during DATA bit 2
    send(8'h55, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.p_data_in  = 8'hFF;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b1;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    wait_idle("frame_55");
    repeat (4) @(negedge clk);
    chk("55_data_reg_kept", {24'd0, bus.data_reg}, 32'h55);
    chk("55_no_second_frame", {31'd0, bus.busy}, 32'd0);

    // Reset asserted at DATA bit 3 of 0x0F
    send(8'h0F, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_mux_sel", {30'd0, bus.mux_sel}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_data_reg", {24'd0, bus.data_reg}, 32'd0);
    chk("midrst_ser_bit", {31'd0, bus.ser_bit}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'hF0, 1'b0, 1'b0);
    wait_idle("frame_f0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
